// File: rtl/axi_ctrl_access_arb_if.sv
// AXI4-Lite slave-side bundle for the control register access arbiter.
// The slave modport is the arbiter, the master modport is the bus initiator.
interface axi_ctrl_access_arb_if #(
    parameter int C_ADDR_WIDTH = 32,
    parameter int C_DATA_WIDTH = 32
);
    logic                    awvalid;
    logic                    awready;
    logic [C_ADDR_WIDTH-1:0] awaddr;
    logic                    wvalid;
    logic                    wready;
    logic [C_DATA_WIDTH-1:0] wdata;
    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;
    logic                    arvalid;
    logic                    arready;
    logic [C_ADDR_WIDTH-1:0] araddr;
    logic                    rvalid;
    logic                    rready;
    logic [C_DATA_WIDTH-1:0] rdata;
    logic [1:0]              rresp;

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport master (
        output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_ctrl_access_arb.sv
// AXI4-Lite to register-bank bridge: arbitrates AW against AR, decodes the address to a
// register index and issues single-cycle write/read strobes, one transaction at a time.
module axi_ctrl_access_arb #(
    parameter int C_ADDR_WIDTH    = 32,
    parameter int C_DATA_WIDTH    = 32,
    parameter int C_NUM_REG       = 4,
    parameter int C_NUM_REG_WIDTH = 2,
    parameter logic [C_NUM_REG*C_ADDR_WIDTH-1:0] C_REG_ADDR_ARRAY =
        128'h0000_F00C_0000_F008_0000_F004_0000_F000,
    parameter logic [C_NUM_REG-1:0] C_REG_WRAC_ARRAY = 4'b1111,
    parameter logic [C_NUM_REG-1:0] C_REG_RDAC_ARRAY = 4'b1111
) (
    input  logic                       clk,
    input  logic                       reset_n,
    axi_ctrl_access_arb_if.slave       s_axi,
    output logic [C_NUM_REG_WIDTH-1:0] reg_sel,
    output logic                       reg_wr,
    output logic [C_DATA_WIDTH-1:0]    reg_wdata,
    output logic                       reg_rd,
    input  logic [C_DATA_WIDTH-1:0]    reg_rdata
);

    typedef enum logic [2:0] {IDLE, WAIT_W, WR, BRESP, RD, RDATA} state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t                     state_q, state_d;
    logic                       last_wr_q, last_wr_d;
    logic                       hit_q, hit_d;
    logic [C_NUM_REG_WIDTH-1:0] sel_q, sel_d;
    logic [C_DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [C_DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic [1:0]                 bresp_q, bresp_d;
    logic [1:0]                 rresp_q, rresp_d;

    logic grant_wr, grant_rd, wr_ok, rd_ok;
    logic awready, arready, wready, bvalid, rvalid;

    // Iterating downward lets the lowest matching entry overwrite any higher match.
    function automatic logic [C_NUM_REG_WIDTH:0] decode(input logic [C_ADDR_WIDTH-1:0] addr);
        logic                       hit;
        logic [C_NUM_REG_WIDTH-1:0] idx;
        hit = 1'b0;
        idx = '0;
        for (int i = C_NUM_REG - 1; i >= 0; i--) begin
            if (addr == C_REG_ADDR_ARRAY[i*C_ADDR_WIDTH +: C_ADDR_WIDTH]) begin
                hit = 1'b1;
                idx = i[C_NUM_REG_WIDTH-1:0];
            end
        end
        return {hit, idx};
    endfunction

    assign grant_wr = s_axi.awvalid & (~s_axi.arvalid | ~last_wr_q);
    assign grant_rd = s_axi.arvalid & (~s_axi.awvalid |  last_wr_q);
    assign wr_ok    = hit_q & C_REG_WRAC_ARRAY[sel_q];
    assign rd_ok    = hit_q & C_REG_RDAC_ARRAY[sel_q];

    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        hit_d     = hit_q;
        sel_d     = sel_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        bresp_d   = bresp_q;
        rresp_d   = rresp_q;
        awready   = 1'b0;
        arready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        rvalid    = 1'b0;
        reg_wr    = 1'b0;
        reg_rd    = 1'b0;
        case (state_q)
            IDLE: begin
                // Readies are combinational, so they must also be held low during reset.
                awready = grant_wr & reset_n;
                arready = grant_rd & reset_n;
                if (awready) begin
                    {hit_d, sel_d} = decode(s_axi.awaddr);
                    last_wr_d      = 1'b1;
                    state_d        = WAIT_W;
                end else if (arready) begin
                    {hit_d, sel_d} = decode(s_axi.araddr);
                    last_wr_d      = 1'b0;
                    state_d        = RD;
                end
            end
            WAIT_W: begin
                wready = 1'b1;
                if (s_axi.wvalid) begin
                    wdata_d = s_axi.wdata;
                    state_d = WR;
                end
            end
            WR: begin
                reg_wr  = wr_ok;
                bresp_d = wr_ok ? RESP_OKAY : RESP_SLVERR;
                state_d = BRESP;
            end
            BRESP: begin
                bvalid = 1'b1;
                if (s_axi.bready) begin
                    sel_d   = '0;
                    state_d = IDLE;
                end
            end
            RD: begin
                reg_rd  = rd_ok;
                rdata_d = rd_ok ? reg_rdata : '0;
                rresp_d = rd_ok ? RESP_OKAY : RESP_SLVERR;
                state_d = RDATA;
            end
            RDATA: begin
                rvalid = 1'b1;
                if (s_axi.rready) begin
                    sel_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            last_wr_q <= 1'b1;
            hit_q     <= 1'b0;
            sel_q     <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            bresp_q   <= 2'b00;
            rresp_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
            hit_q     <= hit_d;
            sel_q     <= sel_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
        end
    end

    assign s_axi.awready = awready;
    assign s_axi.arready = arready;
    assign s_axi.wready  = wready;
    assign s_axi.bvalid  = bvalid;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.rvalid  = rvalid;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;
    assign reg_sel       = sel_q;
    assign reg_wdata     = wdata_q;

endmodule

// File: tb/tb_axi_ctrl_access_arb.sv
// Randomized scoreboard bench for axi_ctrl_access_arb: the driver predicts each response
// from a register-map model, a negedge monitor checks strobes and responses against it.
module tb_axi_ctrl_access_arb;

    logic        clk;
    logic        reset_n;
    logic [1:0]  reg_sel;
    logic        reg_wr;
    logic [31:0] reg_wdata;
    logic        reg_rd;
    logic [31:0] reg_rdata;
    int          cyc;
    int          n_total;
    int          n_pass;

    axi_ctrl_access_arb_if #(.C_ADDR_WIDTH(32), .C_DATA_WIDTH(32)) ifc ();

    axi_ctrl_access_arb #(
        .C_ADDR_WIDTH     (32),
        .C_DATA_WIDTH     (32),
        .C_NUM_REG        (4),
        .C_NUM_REG_WIDTH  (2),
        .C_REG_ADDR_ARRAY (128'h0000_F00C_0000_F008_0000_F004_0000_F000),
        .C_REG_WRAC_ARRAY (4'b1110),
        .C_REG_RDAC_ARRAY (4'b0111)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_axi     (ifc),
        .reg_sel   (reg_sel),
        .reg_wr    (reg_wr),
        .reg_wdata (reg_wdata),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Register-bank peripheral: written only by the DUT strobe, read combinationally.
    logic [31:0] periph [4] = '{default: 32'h0};
    assign reg_rdata = periph[reg_sel];
    always @(posedge clk) if (reg_wr) periph[reg_sel] <= reg_wdata;

    // Reference register map and model state.
    logic [31:0] addr_tab [4] = '{32'hF000, 32'hF004, 32'hF008, 32'hF00C};
    bit          wrac_tab [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    bit          rdac_tab [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] model_regs [4] = '{default: 32'h0};
    bit          model_last_wr = 1'b1;

    typedef struct {
        bit          wr;
        logic [1:0]  sel;
        logic [31:0] data;
        logic [1:0]  resp;
        int          strobe;
    } exp_t;
    exp_t expq[$];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, exp, cyc);
    endtask

    task automatic timeout_fail(input string nm);
        n_total++;
        $display("FAIL %s: timed out waiting, got 0, expected 1 (cycle %0d)", nm, cyc);
    endtask

    function automatic int lookup(input logic [31:0] a);
        for (int i = 0; i < 4; i++) if (a == addr_tab[i]) return i;
        return -1;
    endfunction

    function automatic void push_write(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int   i;
        bit   ok;
        i  = lookup(a);
        ok = 1'b0;
        if (i >= 0) ok = wrac_tab[i];
        e.wr = 1'b1;
        e.sel = (i >= 0) ? 2'(i) : 2'd0;
        e.data = d;
        e.resp = ok ? 2'b00 : 2'b10;
        e.strobe = ok ? 1 : 0;
        if (ok) model_regs[i] = d;
        expq.push_back(e);
        model_last_wr = 1'b1;
    endfunction

    function automatic void push_read(input logic [31:0] a);
        exp_t e;
        int   i;
        bit   ok;
        i  = lookup(a);
        ok = 1'b0;
        if (i >= 0) ok = rdac_tab[i];
        e.wr = 1'b0;
        e.sel = (i >= 0) ? 2'(i) : 2'd0;
        e.data = 32'h0;
        if (ok) e.data = model_regs[i];
        e.resp = ok ? 2'b00 : 2'b10;
        e.strobe = ok ? 1 : 0;
        expq.push_back(e);
        model_last_wr = 1'b0;
    endfunction

    function automatic logic [31:0] rand_addr();
        int k;
        k = int'($urandom_range(0, 4));
        if (k == 4) return {16'h0, 16'($urandom_range(0, 16'hEFFF))};
        return addr_tab[k];
    endfunction

    function automatic bit sig(input int s);
        case (s)
            0:       return ifc.awready;
            1:       return ifc.arready;
            2:       return ifc.wready;
            3:       return ifc.bvalid;
            4:       return ifc.rvalid;
            default: return ifc.awready | ifc.arready;
        endcase
    endfunction

    task automatic wait_sig(input int s, input string nm, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (n < 200) begin
            @(negedge clk);
            if (sig(s)) begin
                ok = 1'b1;
                return;
            end
            n++;
        end
        timeout_fail(nm);
    endtask

    task automatic finish_write(input logic [31:0] d, input int stall);
        bit ok;
        ifc.wvalid = 1'b1;
        ifc.wdata  = d;
        wait_sig(2, "wready", ok);
        @(posedge clk); #1;
        ifc.wvalid = 1'b0;
        wait_sig(3, "bvalid", ok);
        repeat (stall) @(posedge clk);
        #1 ifc.bready = 1'b1;
        @(posedge clk); #1;
        ifc.bready = 1'b0;
    endtask

    task automatic finish_read(input int stall);
        bit ok;
        wait_sig(4, "rvalid", ok);
        repeat (stall) @(posedge clk);
        #1 ifc.rready = 1'b1;
        @(posedge clk); #1;
        ifc.rready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input bit early, input int stall);
        bit ok;
        if (early) begin
            ifc.wvalid = 1'b1;
            ifc.wdata  = d;
            repeat (3) @(posedge clk);
            #1;
        end
        ifc.awvalid = 1'b1;
        ifc.awaddr  = a;
        wait_sig(0, "awready", ok);
        @(posedge clk); #1;
        ifc.awvalid = 1'b0;
        push_write(a, d);
        finish_write(d, stall);
    endtask

    task automatic do_read(input logic [31:0] a, input int stall);
        bit ok;
        ifc.arvalid = 1'b1;
        ifc.araddr  = a;
        wait_sig(1, "arready", ok);
        @(posedge clk); #1;
        ifc.arvalid = 1'b0;
        push_read(a);
        finish_read(stall);
    endtask

    // Both requesters asserted; the served one is re-raised nraise times in total.
    // The first ncheck grants are also compared against the fixed order read, write, read, ...
    task automatic run_both(input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] ra,
                            input int nraise, input int ncheck);
        int served;
        bit ok, exp_rd, got_rd;
        served = 0;
        ifc.awvalid = 1'b1;
        ifc.awaddr  = wa;
        ifc.arvalid = 1'b1;
        ifc.araddr  = ra;
        while (ifc.awvalid || ifc.arvalid) begin
            wait_sig(5, "grant", ok);
            if (!ok) begin
                ifc.awvalid = 1'b0;
                ifc.arvalid = 1'b0;
                return;
            end
            exp_rd = ifc.arvalid && (!ifc.awvalid || model_last_wr);
            got_rd = ifc.arready;
            chk("grant", {ifc.awready, ifc.arready}, {!exp_rd, exp_rd});
            if (served < ncheck) chk("tie_order_rd", got_rd, (served % 2) == 0);
            @(posedge clk); #1;
            if (got_rd) begin
                ifc.arvalid = 1'b0;
                push_read(ra);
                finish_read(int'($urandom_range(0, 2)));
                if (served < nraise) begin
                    ra = rand_addr();
                    ifc.arvalid = 1'b1;
                    ifc.araddr  = ra;
                end
            end else begin
                ifc.awvalid = 1'b0;
                push_write(wa, wd);
                finish_write(wd, int'($urandom_range(0, 2)));
                if (served < nraise) begin
                    wa = rand_addr();
                    wd = $urandom;
                    ifc.awvalid = 1'b1;
                    ifc.awaddr  = wa;
                end
            end
            served++;
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    initial begin : monitor
        bit          w_open, prev_b, prev_r;
        int          strobe_cnt, w_hs, ar_hs;
        logic [1:0]  hold_bresp, hold_rresp;
        logic [31:0] hold_rdata;
        exp_t        e;
        w_open = 0; prev_b = 0; prev_r = 0; strobe_cnt = 0; w_hs = 0; ar_hs = 0;
        hold_bresp = 0; hold_rresp = 0; hold_rdata = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                w_open = 0; prev_b = 0; prev_r = 0; strobe_cnt = 0;
                expq.delete();
            end else begin
                chk("ready_exclusive", ifc.awready & ifc.arready, 1'b0);
                chk("strobe_exclusive", reg_wr & reg_rd, 1'b0);
                chk("wready", ifc.wready, w_open);
                if (ifc.awvalid && ifc.awready) begin
                    w_open = 1; strobe_cnt = 0;
                end else if (ifc.wvalid && ifc.wready) begin
                    w_open = 0; w_hs = cyc;
                end
                if (ifc.arvalid && ifc.arready) begin
                    ar_hs = cyc; strobe_cnt = 0;
                end
                if (reg_wr || reg_rd) begin
                    if (expq.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_strobe: got wr=%0b rd=%0b, expected none", reg_wr, reg_rd);
                    end else begin
                        e = expq[0];
                        chk("strobe_kind", reg_wr, e.wr);
                        chk("strobe_sel", reg_sel, e.sel);
                        if (reg_wr) begin
                            chk("reg_wdata", reg_wdata, e.data);
                            chk("wr_latency", cyc, w_hs + 1);
                        end else begin
                            chk("rd_latency", cyc, ar_hs + 1);
                        end
                    end
                    strobe_cnt++;
                end
                if (ifc.bvalid && !prev_b) begin
                    if (expq.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_bvalid: got bvalid=1, expected 0");
                    end else begin
                        e = expq.pop_front();
                        chk("b_kind", 1'b1, e.wr);
                        chk("bresp", ifc.bresp, e.resp);
                        chk("b_sel", reg_sel, e.sel);
                        chk("wr_strobes", strobe_cnt, e.strobe);
                        chk("b_latency", cyc, w_hs + 2);
                    end
                    hold_bresp = ifc.bresp;
                end else if (ifc.bvalid) begin
                    chk("bresp_stable", ifc.bresp, hold_bresp);
                end
                prev_b = ifc.bvalid && !ifc.bready;
                if (ifc.rvalid && !prev_r) begin
                    if (expq.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_rvalid: got rvalid=1, expected 0");
                    end else begin
                        e = expq.pop_front();
                        chk("r_kind", 1'b0, e.wr);
                        chk("rresp", ifc.rresp, e.resp);
                        chk("rdata", ifc.rdata, e.data);
                        chk("r_sel", reg_sel, e.sel);
                        chk("rd_strobes", strobe_cnt, e.strobe);
                        chk("r_latency", cyc, ar_hs + 2);
                    end
                    hold_rresp = ifc.rresp;
                    hold_rdata = ifc.rdata;
                end else if (ifc.rvalid) begin
                    chk("rresp_stable", ifc.rresp, hold_rresp);
                    chk("rdata_stable", ifc.rdata, hold_rdata);
                end
                prev_r = ifc.rvalid && !ifc.rready;
            end
        end
    end

    task automatic check_quiet(input string tag);
        chk({tag, "_awready"}, ifc.awready, 1'b0);
        chk({tag, "_arready"}, ifc.arready, 1'b0);
        chk({tag, "_wready"}, ifc.wready, 1'b0);
        chk({tag, "_bvalid"}, ifc.bvalid, 1'b0);
        chk({tag, "_rvalid"}, ifc.rvalid, 1'b0);
        chk({tag, "_reg_wr"}, reg_wr, 1'b0);
        chk({tag, "_reg_rd"}, reg_rd, 1'b0);
        chk({tag, "_bresp"}, ifc.bresp, 2'b00);
        chk({tag, "_rresp"}, ifc.rresp, 2'b00);
        chk({tag, "_rdata"}, ifc.rdata, 32'h0);
        chk({tag, "_reg_wdata"}, reg_wdata, 32'h0);
        chk({tag, "_reg_sel"}, reg_sel, 2'd0);
    endtask

    initial begin : driver
        bit ok;
        cyc = 0; n_total = 0; n_pass = 0;
        reset_n = 1'b0;
        ifc.awvalid = 0; ifc.awaddr = 0; ifc.wvalid = 0; ifc.wdata = 0; ifc.bready = 0;
        ifc.arvalid = 0; ifc.araddr = 0; ifc.rready = 0;
        repeat (3) @(posedge clk);
        #1;
        ifc.awvalid = 1'b1;
        ifc.arvalid = 1'b1;
        ifc.wvalid  = 1'b1;
        #1 check_quiet("reset");
        ifc.awvalid = 1'b0;
        ifc.arvalid = 1'b0;
        ifc.wvalid  = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        do_write(32'hF008, 32'hDEADBEEF, 1'b0, 1);
        do_write(32'hF004, 32'h12345678, 1'b0, 0);
        do_read(32'hF004, 3);
        do_write(32'h0000_1234, 32'h1111_1111, 1'b0, 0);
        do_write(32'hF000, 32'h2222_2222, 1'b0, 0);
        do_read(32'h0000_5678, 0);
        do_write(32'hF00C, 32'hCAFEF00D, 1'b0, 0);
        do_read(32'hF00C, 1);
        do_read(32'hF008, 0);
        do_write(32'hF00C, 32'hA5A5_5A5A, 1'b1, 0);
        run_both(32'hF008, 32'h0BADC0DE, 32'hF004, 3, 4);

        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 2))
                0: do_write(rand_addr(), $urandom, $urandom_range(0, 5) == 0, int'($urandom_range(0, 3)));
                1: do_read(rand_addr(), int'($urandom_range(0, 3)));
                default: run_both(rand_addr(), $urandom, rand_addr(), int'($urandom_range(0, 2)), 0);
            endcase
        end

        // Abort a write while its response is stalled, then confirm the arbiter restarts clean.
        ifc.awvalid = 1'b1;
        ifc.awaddr  = 32'hF008;
        wait_sig(0, "awready", ok);
        @(posedge clk); #1;
        ifc.awvalid = 1'b0;
        push_write(32'hF008, 32'h7777_0001);
        ifc.wvalid = 1'b1;
        ifc.wdata  = 32'h7777_0001;
        wait_sig(2, "wready", ok);
        @(posedge clk); #1;
        ifc.wvalid = 1'b0;
        wait_sig(3, "bvalid", ok);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1 check_quiet("abort");
        expq.delete();
        model_last_wr = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_both(32'hF00C, 32'h0F0F_0F0F, 32'hF008, 0, 1);
        do_read(32'hF00C, 0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
